ctrl_decode_pipe: RTL and testbench

- Registered successor to the combinational main decoder.
- Decodes a full 32-bit MIPS instruction in the D stage and registers the control word plus the resolved destination register into the ID/EX register.
- Detects load-use hazards and inserts bubbles.
- Tracks a multi-cycle mult/div unit and stalls HI/LO consumers while it is busy.
- Sits between the IF/ID register and the EX stage.

---
 rtl/ctrl_decode_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// Registered MIPS main decoder: D-stage decode into ID/EX with load-use and mult/div hazard stalls.
// Optional illegal-opcode flag enabled by defining CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_pipe #(
    parameter int unsigned ALUOP_W    = 6,
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [31:0]        i_instr,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_ex_valid,
    output logic               o_ex_regdst,
    output logic               o_ex_alusrc,
    output logic               o_ex_memread,
    output logic               o_ex_memwrite,
    output logic               o_ex_memtoreg,
    output logic               o_ex_regwrite,
    output logic               o_ex_ifsign,
    output logic [ALUOP_W-1:0] o_ex_aluop,
    output logic [4:0]         o_ex_wreg,
    output logic               o_ex_muldiv_start,
    output logic               o_muldiv_busy,
    output logic               o_ex_illegal
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_JAL   = 6'b000011,
        OP_ADDI  = 6'b001000,
        OP_ADDIU = 6'b001001,
        OP_SLTI  = 6'b001010,
        OP_SLTIU = 6'b001011,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011
    } opcode_e;

    opcode_e     opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        unused_shamt;

    assign opcode       = opcode_e'(i_instr[31:26]);
    assign rs           = i_instr[25:21];
    assign rt           = i_instr[20:16];
    assign rd           = i_instr[15:11];
    assign funct        = i_instr[5:0];
    assign unused_shamt = ^i_instr[10:6];

    // {regdst, regwrite, alusrc, memread, memwrite, memtoreg, ifsign, aluop[5:0]}
    logic [12:0] dec_ctl;
    logic        dec_regdst, dec_regwrite, dec_alusrc, dec_memread;
    logic        dec_memwrite, dec_memtoreg, dec_ifsign;
    logic [5:0]  dec_aluop;
    logic [4:0]  dec_wreg;

    always_comb begin
        dec_ctl = '0;
        if (i_instr[31:29] == 3'b101) begin
            dec_ctl = 13'b0_0_1_0_1_0_1_000000;
        end else begin
            case (opcode)
                OP_RTYPE:         dec_ctl = 13'b1_1_0_0_0_0_0_000010;
                OP_ADDI, OP_ADDIU: dec_ctl = 13'b0_1_1_0_0_0_1_000011;
                OP_ANDI:          dec_ctl = 13'b0_1_1_0_0_0_0_000111;
                OP_ORI:           dec_ctl = 13'b0_1_1_0_0_0_0_001011;
                OP_XORI:          dec_ctl = 13'b0_1_1_0_0_0_0_001111;
                OP_LW:            dec_ctl = 13'b0_1_1_1_0_1_1_000000;
                OP_LUI:           dec_ctl = 13'b0_1_1_0_0_0_1_011111;
                OP_SLTI:          dec_ctl = 13'b0_1_1_0_0_0_1_011011;
                OP_SLTIU:         dec_ctl = 13'b0_1_1_0_0_0_0_100111;
                OP_JAL:           dec_ctl = 13'b0_1_0_0_0_0_0_000000;
                default:          dec_ctl = '0;
            endcase
        end
    end

    assign {dec_regdst, dec_regwrite, dec_alusrc, dec_memread,
            dec_memwrite, dec_memtoreg, dec_ifsign, dec_aluop} = dec_ctl;

    always_comb begin
        dec_wreg = '0;
        if (dec_regwrite) begin
            if (opcode == OP_JAL)  dec_wreg = 5'd31;
            else if (dec_regdst)   dec_wreg = rd;
            else                   dec_wreg = rt;
        end
    end

    logic is_rtype, rt_is_source, is_muldiv, uses_hilo;
    assign is_rtype     = (opcode == OP_RTYPE);
    assign rt_is_source = is_rtype | (i_instr[31:29] == 3'b101);
    assign is_muldiv    = is_rtype & (funct[5:2] == 4'b0110);
    assign uses_hilo    = is_muldiv | (is_rtype & ((funct == 6'b010000) | (funct == 6'b010010)));

    logic               ex_valid_q, ex_regdst_q, ex_alusrc_q, ex_memread_q;
    logic               ex_memwrite_q, ex_memtoreg_q, ex_regwrite_q, ex_ifsign_q;
    logic [ALUOP_W-1:0] ex_aluop_q;
    logic [4:0]         ex_wreg_q;
    logic               ex_start_q, ex_illegal_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               ex_valid_d, ex_regdst_d, ex_alusrc_d, ex_memread_d;
    logic               ex_memwrite_d, ex_memtoreg_d, ex_regwrite_d, ex_ifsign_d;
    logic [ALUOP_W-1:0] ex_aluop_d;
    logic [4:0]         ex_wreg_d;
    logic               ex_start_d, ex_illegal_d;
    logic [CNT_W-1:0]   cnt_d;

    logic load_use, md_stall, busy, accept;

    assign busy     = (cnt_q != '0);
    assign load_use = i_valid & ex_valid_q & ex_memread_q & (ex_wreg_q != '0) &
                      ((ex_wreg_q == rs) | ((ex_wreg_q == rt) & rt_is_source));
    assign md_stall = i_valid & busy & uses_hilo;
    assign o_stall  = (load_use | md_stall) & ~i_flush & ~i_rst;
    assign accept   = i_valid & ~i_flush & ~o_stall;

    // Flush, stall and idle all share the bubble path: every field defaults to zero.
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_regdst_d   = 1'b0;
        ex_alusrc_d   = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        ex_memtoreg_d = 1'b0;
        ex_regwrite_d = 1'b0;
        ex_ifsign_d   = 1'b0;
        ex_aluop_d    = '0;
        ex_wreg_d     = '0;
        ex_start_d    = 1'b0;
        ex_illegal_d  = 1'b0;
        if (accept) begin
            ex_valid_d    = 1'b1;
            ex_regdst_d   = dec_regdst;
            ex_alusrc_d   = dec_alusrc;
            ex_memread_d  = dec_memread;
            ex_memwrite_d = dec_memwrite;
            ex_memtoreg_d = dec_memtoreg;
            ex_regwrite_d = dec_regwrite;
            ex_ifsign_d   = dec_ifsign;
            ex_aluop_d    = ALUOP_W'(dec_aluop);
            ex_wreg_d     = dec_wreg;
            ex_start_d    = is_muldiv;
`ifdef CTRL_ILLEGAL_TRAP_EN
            // Every table entry writes a register or memory, so neither means unknown.
            ex_illegal_d  = ~(dec_regwrite | dec_memwrite);
`endif
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept & is_muldiv) cnt_d = CNT_W'(MULDIV_LAT);
        else if (busy)          cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q    <= 1'b0;
            ex_regdst_q   <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_ifsign_q   <= 1'b0;
            ex_aluop_q    <= '0;
            ex_wreg_q     <= '0;
            ex_start_q    <= 1'b0;
            ex_illegal_q  <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regdst_q   <= ex_regdst_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_ifsign_q   <= ex_ifsign_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_wreg_q     <= ex_wreg_d;
            ex_start_q    <= ex_start_d;
            ex_illegal_q  <= ex_illegal_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_ex_valid        = ex_valid_q;
    assign o_ex_regdst       = ex_regdst_q;
    assign o_ex_alusrc       = ex_alusrc_q;
    assign o_ex_memread      = ex_memread_q;
    assign o_ex_memwrite     = ex_memwrite_q;
    assign o_ex_memtoreg     = ex_memtoreg_q;
    assign o_ex_regwrite     = ex_regwrite_q;
    assign o_ex_ifsign       = ex_ifsign_q;
    assign o_ex_aluop        = ex_aluop_q;
    assign o_ex_wreg         = ex_wreg_q;
    assign o_ex_muldiv_start = ex_start_q;
    assign o_muldiv_busy     = busy;
    assign o_ex_illegal      = ex_illegal_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: table-driven reference model checked every cycle, plus directed literal checks.
module tb_ctrl_decode_pipe;

    localparam int LAT = 32;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    localparam logic [31:0] ADDI   = 32'h2008_0005;
    localparam logic [31:0] LW9    = 32'h8C09_0000;
    localparam logic [31:0] ADD10  = 32'h012B_5020;
    localparam logic [31:0] LW0    = 32'h8C00_0000;
    localparam logic [31:0] ADD_Z  = 32'h0000_5020;
    localparam logic [31:0] ORI9   = 32'h3409_0001;
    localparam logic [31:0] MULT   = 32'h0109_0018;
    localparam logic [31:0] MFLO12 = 32'h0000_6012;
    localparam logic [31:0] JAL    = 32'h0C00_0000;
    localparam logic [31:0] SW     = 32'hAD09_0004;
    localparam logic [31:0] ILLOP  = 32'hFC00_0000;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_flush;
    logic [31:0] i_instr;
    logic        o_stall, o_ex_valid, o_ex_regdst, o_ex_alusrc, o_ex_memread;
    logic        o_ex_memwrite, o_ex_memtoreg, o_ex_regwrite, o_ex_ifsign;
    logic [5:0]  o_ex_aluop;
    logic [4:0]  o_ex_wreg;
    logic        o_ex_muldiv_start, o_muldiv_busy, o_ex_illegal;

    ctrl_decode_pipe #(.ALUOP_W(6), .MULDIV_LAT(LAT), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr), .i_flush(i_flush),
        .o_stall(o_stall), .o_ex_valid(o_ex_valid), .o_ex_regdst(o_ex_regdst),
        .o_ex_alusrc(o_ex_alusrc), .o_ex_memread(o_ex_memread), .o_ex_memwrite(o_ex_memwrite),
        .o_ex_memtoreg(o_ex_memtoreg), .o_ex_regwrite(o_ex_regwrite), .o_ex_ifsign(o_ex_ifsign),
        .o_ex_aluop(o_ex_aluop), .o_ex_wreg(o_ex_wreg), .o_ex_muldiv_start(o_ex_muldiv_start),
        .o_muldiv_busy(o_muldiv_busy), .o_ex_illegal(o_ex_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       valid, regdst, alusrc, memread, memwrite, memtoreg, regwrite, ifsign;
        logic [5:0] aluop;
        logic [4:0] wreg;
        logic       start, illegal;
    } exw_t;

    exw_t m;
    int   cnt;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic last_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exw_t model_decode(input logic [31:0] ins);
        logic [12:0] t;
        logic        known;
        logic [5:0]  op, fn;
        exw_t        w;
        op = ins[31:26];
        fn = ins[5:0];
        known = 1'b1;
        if (op[5:3] == 3'b101) t = 13'b0_0_1_0_1_0_1_000000;
        else begin
            case (op)
                6'b000000: t = 13'b1_1_0_0_0_0_0_000010;
                6'b001000,
                6'b001001: t = 13'b0_1_1_0_0_0_1_000011;
                6'b001100: t = 13'b0_1_1_0_0_0_0_000111;
                6'b001101: t = 13'b0_1_1_0_0_0_0_001011;
                6'b001110: t = 13'b0_1_1_0_0_0_0_001111;
                6'b100011: t = 13'b0_1_1_1_0_1_1_000000;
                6'b001111: t = 13'b0_1_1_0_0_0_1_011111;
                6'b001010: t = 13'b0_1_1_0_0_0_1_011011;
                6'b001011: t = 13'b0_1_1_0_0_0_0_100111;
                6'b000011: t = 13'b0_1_0_0_0_0_0_000000;
                default: begin t = '0; known = 1'b0; end
            endcase
        end
        w = '0;
        w.valid = 1'b1;
        {w.regdst, w.regwrite, w.alusrc, w.memread, w.memwrite, w.memtoreg, w.ifsign, w.aluop} = t;
        if (!w.regwrite)        w.wreg = 5'd0;
        else if (op == 6'd3)    w.wreg = 5'd31;
        else if (w.regdst)      w.wreg = ins[15:11];
        else                    w.wreg = ins[20:16];
        w.start = (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
`ifdef CTRL_ILLEGAL_TRAP_EN
        w.illegal = !known;
`else
        if (!known) w.illegal = 1'b0;
`endif
        return w;
    endfunction

    function automatic logic model_stall();
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic       lu, hilo, md;
        op = i_instr[31:26];
        fn = i_instr[5:0];
        rs = i_instr[25:21];
        rt = i_instr[20:16];
        lu = i_valid && m.valid && m.memread && (m.wreg != 0) &&
             ((m.wreg == rs) || ((m.wreg == rt) && ((op == 0) || (op[5:3] == 3'b101))));
        hilo = (op == 0) && ((fn == 16) || (fn == 18) || ((fn >= 24) && (fn <= 27)));
        md = i_valid && (cnt != 0) && hilo;
        return (lu || md) && !i_flush && !i_rst;
    endfunction

    task automatic model_update();
        logic st, acc;
        exw_t nw;
        if (i_rst) begin
            m = '0;
            cnt = 0;
        end else begin
            st  = model_stall();
            acc = i_valid && !i_flush && !st;
            nw  = acc ? model_decode(i_instr) : '0;
            if (acc && nw.start) cnt = LAT;
            else if (cnt != 0)   cnt = cnt - 1;
            m = nw;
        end
        chk_en = 1'b1;
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("stall", {31'd0, o_stall}, {31'd0, model_stall()});
            check("ex_word", {11'd0, o_ex_valid, o_ex_regdst, o_ex_alusrc, o_ex_memread, o_ex_memwrite,
                              o_ex_memtoreg, o_ex_regwrite, o_ex_ifsign, o_ex_aluop, o_ex_wreg,
                              o_ex_muldiv_start, o_ex_illegal}, {11'd0, m});
            check("busy", {31'd0, o_muldiv_busy}, {31'd0, cnt != 0});
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic r);
        i_valid = v;
        i_instr = ins;
        i_flush = fl;
        i_rst   = r;
        @(negedge i_clk);
        last_stall = o_stall;
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    int n;

    initial begin
        m = '0;
        cnt = 0;
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, ADDI, 1'b0, 1'b1);
        check("rst_valid", {31'd0, o_ex_valid}, 32'd0);
        check("rst_busy", {31'd0, o_muldiv_busy}, 32'd0);
        check("rst_stall", {31'd0, last_stall}, 32'd0);

        step(1'b1, ADDI, 1'b0, 1'b0);
        check("addi_valid", {31'd0, o_ex_valid}, 32'd1);
        check("addi_aluop", {26'd0, o_ex_aluop}, 32'b000011);
        check("addi_alusrc", {31'd0, o_ex_alusrc}, 32'd1);
        check("addi_ifsign", {31'd0, o_ex_ifsign}, 32'd1);
        check("addi_wreg", {27'd0, o_ex_wreg}, 32'd8);

        step(1'b1, LW9, 1'b0, 1'b0);
        check("lw_memread", {31'd0, o_ex_memread}, 32'd1);
        step(1'b1, ADD10, 1'b0, 1'b0);
        check("lu_stall", {31'd0, last_stall}, 32'd1);
        check("lu_bubble", {31'd0, o_ex_valid}, 32'd0);
        step(1'b1, ADD10, 1'b0, 1'b0);
        check("lu_retry_stall", {31'd0, last_stall}, 32'd0);
        check("add_wreg", {27'd0, o_ex_wreg}, 32'd10);
        check("add_regdst", {31'd0, o_ex_regdst}, 32'd1);

        step(1'b1, LW0, 1'b0, 1'b0);
        step(1'b1, ADD_Z, 1'b0, 1'b0);
        check("lw_r0_nostall", {31'd0, last_stall}, 32'd0);
        step(1'b1, LW9, 1'b0, 1'b0);
        step(1'b1, ORI9, 1'b0, 1'b0);
        check("ori_rt_nostall", {31'd0, last_stall}, 32'd0);
        check("ori_wreg", {27'd0, o_ex_wreg}, 32'd9);

        step(1'b1, JAL, 1'b0, 1'b0);
        check("jal_wreg", {27'd0, o_ex_wreg}, 32'd31);
        step(1'b1, SW, 1'b0, 1'b0);
        check("sw_regwrite", {31'd0, o_ex_regwrite}, 32'd0);
        check("sw_wreg", {27'd0, o_ex_wreg}, 32'd0);
        check("sw_memwrite", {31'd0, o_ex_memwrite}, 32'd1);
        foreach (ADDI[i]) if (i < 1) begin
            step(1'b1, 32'h3C0A_1234, 1'b0, 1'b0);
            step(1'b1, 32'h2D0B_0007, 1'b0, 1'b0);
            step(1'b1, 32'h390C_00FF, 1'b0, 1'b0);
        end
        check("xori_aluop", {26'd0, o_ex_aluop}, 32'b001111);

        step(1'b1, MULT, 1'b0, 1'b0);
        check("mult_start", {31'd0, o_ex_muldiv_start}, 32'd1);
        check("mult_busy", {31'd0, o_muldiv_busy}, 32'd1);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, MFLO12, 1'b0, 1'b0);
            if (!last_stall) break;
            n++;
        end
        check("mflo_stall_cycles", n, 32'd32);
        check("mflo_valid", {31'd0, o_ex_valid}, 32'd1);
        check("mflo_wreg", {27'd0, o_ex_wreg}, 32'd12);
        check("mflo_start", {31'd0, o_ex_muldiv_start}, 32'd0);

        step(1'b1, MULT, 1'b0, 1'b0);
        for (int k = 0; k < LAT - 1; k++) step(1'b0, 32'd0, 1'b0, 1'b0);
        check("cnt_at_one_busy", {31'd0, o_muldiv_busy}, 32'd1);
        step(1'b1, MULT, 1'b0, 1'b0);
        check("mult_at_one_stall", {31'd0, last_stall}, 32'd1);
        step(1'b1, MULT, 1'b0, 1'b0);
        check("mult_after_stall", {31'd0, last_stall}, 32'd0);
        check("mult2_start", {31'd0, o_ex_muldiv_start}, 32'd1);

        step(1'b1, LW9, 1'b0, 1'b0);
        step(1'b1, ADD10, 1'b1, 1'b0);
        check("flush_stall", {31'd0, last_stall}, 32'd0);
        check("flush_bubble", {31'd0, o_ex_valid}, 32'd0);
        check("flush_busy_kept", {31'd0, o_muldiv_busy}, 32'd1);

        for (int k = 0; k < 100 && o_muldiv_busy; k++) step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, MULT, 1'b0, 1'b0);
        for (int k = 0; k < LAT - 10; k++) step(1'b0, 32'd0, 1'b0, 1'b0);
        check("model_cnt10", cnt, 32'd10);
        step(1'b1, MFLO12, 1'b0, 1'b1);
        check("rst_drops_stall", {31'd0, last_stall}, 32'd0);
        check("rst_busy_clear", {31'd0, o_muldiv_busy}, 32'd0);
        check("rst_valid_clear", {31'd0, o_ex_valid}, 32'd0);

        step(1'b1, ILLOP, 1'b0, 1'b0);
        check("illegal_flag", {31'd0, o_ex_illegal}, {31'd0, ILL_EXP});
        check("illegal_valid", {31'd0, o_ex_valid}, 32'd1);
        check("illegal_regwrite", {31'd0, o_ex_regwrite}, 32'd0);
        step(1'b1, ADDI, 1'b0, 1'b0);
        check("illegal_cleared", {31'd0, o_ex_illegal}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("idle_bubble", {31'd0, o_ex_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
